cmul_mul_sequencer: RTL and testbench

Controller that computes one complex product (a+jb)*(c+jd) by time-sharing a single iterative radix-4 Booth real multiplier. The multiplier has an Ld/M/R/Valid/P interface and latency (N+1)/2+1 cycles.
- Issues the four real products ac, bd, ad, bc in sequence.
- Accumulates re = ac - bd and im = ad + bc.
- Presents the result on a valid/ready output.
- Sits between the FFT butterfly's twiddle stage and the shared multiplier instance.

---
 rtl/cmul_pkg.sv | 31 +++
 rtl/cmul_round_sat.sv | 79 +++++++
 rtl/cmul_mul_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_cmul_mul_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmul_pkg.sv
// -----------------------------------------------------------------------------
// cmul_pkg
// Shared definitions for the complex-multiply sequencer:
//   - state_e : sequencer states (IDLE, ISSUE, WAIT, DONE)
//   - step_t  : index of the real product being issued (0..3)
//   - mul_lat : latency of the iterative radix-4 Booth multiplier
//   - SEL_M_B / SEL_R_D : operand-pair selection table indexed by step
// -----------------------------------------------------------------------------
package cmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [1:0] step_t;

    // Step order: 0 -> a*c, 1 -> b*d, 2 -> a*d, 3 -> b*c.
    // SEL_M_B[k] = 1 selects b as multiplicand (else a).
    // SEL_R_D[k] = 1 selects d as multiplier   (else c).
    localparam logic [3:0] SEL_M_B = 4'b1010;
    localparam logic [3:0] SEL_R_D = 4'b0110;

    // Cycles from the Ld cycle to the Valid cycle of the radix-4 Booth multiplier.
    function automatic int unsigned mul_lat(input int unsigned n);
        return (n + 1) / 2 + 1;
    endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// -----------------------------------------------------------------------------
// cmul_round_sat
// Output stage used when CMUL_ROUND_SAT_EN is defined: converts the
// full-precision complex result to a Q1.(N-1) fraction by
// round-half-up(x >>> (N-1)), saturates to [-2^(N-1), 2^(N-1)-1] and
// sign-extends back to OW bits. Adds one register stage to the valid path.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid           : full-precision result is ready (sequencer in DONE)
//   in_re, in_im       : full-precision result, signed OW bits
//   out_ready          : downstream accept
//   out_valid          : registered result valid, held until accepted
//   out_re, out_im     : rounded/saturated result, signed OW bits
// -----------------------------------------------------------------------------
module cmul_round_sat
    import cmul_pkg::*;
#(
    parameter int unsigned N  = 16,
    parameter int unsigned OW = 2 * N + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [OW-1:0] in_re,
    input  logic signed [OW-1:0] in_im,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_re,
    output logic signed [OW-1:0] out_im
);

    // One guard bit above OW so the rounding addend can never wrap.
    localparam logic signed [OW:0] MAX_V = (OW + 1)'(2 ** (N - 1) - 1);
    localparam logic signed [OW:0] MIN_V = ~MAX_V;
    localparam logic signed [OW:0] RND_V = (OW + 1)'(2 ** (N - 2));

    function automatic logic signed [OW-1:0] round_sat(input logic signed [OW-1:0] x);
        logic signed [OW:0] sum;
        logic signed [OW:0] sh;
        sum = {x[OW-1], x} + RND_V;
        sh  = sum >>> (N - 1);
        if (sh > MAX_V) begin
            sh = MAX_V;
        end else if (sh < MIN_V) begin
            sh = MIN_V;
        end
        return OW'(sh);
    endfunction

    logic                 valid_q, valid_d;
    logic signed [OW-1:0] re_q, re_d;
    logic signed [OW-1:0] im_q, im_d;

    always_comb begin
        // Valid follows in_valid one cycle late and drops on the handshake edge,
        // the same edge on which the sequencer leaves DONE.
        valid_d = in_valid && !(valid_q && out_ready);
        re_d    = round_sat(in_re);
        im_d    = round_sat(in_im);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            valid_q <= valid_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign out_valid = valid_q;
    assign out_re    = re_q;
    assign out_im    = im_q;

endmodule

// File: rtl/cmul_mul_sequencer.sv
// -----------------------------------------------------------------------------
// cmul_mul_sequencer
// Computes (a+jb)*(c+jd) by issuing the four real products ac, bd, ad, bc to a
// single external iterative radix-4 Booth multiplier, accumulating
// re = ac - bd and im = ad + bc, and presenting the result on valid/ready.
// One operation in flight at a time; new input is accepted only in IDLE.
//
// Optional feature (macro CMUL_ROUND_SAT_EN): output rounded/saturated to a
// Q1.(N-1) fraction through cmul_round_sat, one extra cycle of latency.
//
// Ports:
//   Clk, Rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   in_a, in_b           : first operand  (real, imaginary), signed N bits
//   in_c, in_d           : second operand (real, imaginary), signed N bits
//   out_valid / out_ready: result handshake, result held until accepted
//   out_re, out_im       : result, signed OW bits
//   busy                 : sequencer not in IDLE
//   mul_ld               : one-cycle start pulse to the multiplier
//   mul_m, mul_r         : multiplicand / multiplier, held outside ISSUE
//   mul_valid, mul_p     : multiplier product pulse and product
// -----------------------------------------------------------------------------
module cmul_mul_sequencer
    import cmul_pkg::*;
#(
    parameter int unsigned N  = 16,
    parameter int unsigned PW = 2 * N,
    parameter int unsigned OW = 2 * N + 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_a,
    input  logic [N-1:0]         in_b,
    input  logic [N-1:0]         in_c,
    input  logic [N-1:0]         in_d,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_re,
    output logic signed [OW-1:0] out_im,
    output logic                 busy,
    output logic                 mul_ld,
    output logic [N-1:0]         mul_m,
    output logic [N-1:0]         mul_r,
    input  logic                 mul_valid,
    input  logic [PW-1:0]        mul_p
);

    function automatic logic [N-1:0] pick_m(input step_t k, input logic [N-1:0] x_a,
                                            input logic [N-1:0] x_b);
        return SEL_M_B[k] ? x_b : x_a;
    endfunction

    function automatic logic [N-1:0] pick_r(input step_t k, input logic [N-1:0] x_c,
                                            input logic [N-1:0] x_d);
        return SEL_R_D[k] ? x_d : x_c;
    endfunction

    state_e               state_q, state_d;
    step_t                k_q, k_d;
    logic [N-1:0]         opa_q, opa_d;
    logic [N-1:0]         opb_q, opb_d;
    logic [N-1:0]         opc_q, opc_d;
    logic [N-1:0]         opd_q, opd_d;
    logic signed [OW-1:0] re_q, re_d;
    logic signed [OW-1:0] im_q, im_d;
    logic                 wait_first_q, wait_first_d;
    logic                 mul_ld_q, mul_ld_d;
    logic [N-1:0]         mul_m_q, mul_m_d;
    logic [N-1:0]         mul_r_q, mul_r_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic signed [OW-1:0] p_ext;

    assign p_ext = OW'($signed(mul_p));

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        opc_d        = opc_q;
        opd_d        = opd_q;
        re_d         = re_q;
        im_d         = im_q;
        wait_first_d = 1'b0;
        mul_ld_d     = 1'b0;
        mul_m_d      = mul_m_q;
        mul_r_d      = mul_r_q;

        // Outputs are registered, so the operand pair and Ld pulse are set up
        // on the edge that enters ISSUE and are therefore live during ISSUE.
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    opa_d    = in_a;
                    opb_d    = in_b;
                    opc_d    = in_c;
                    opd_d    = in_d;
                    k_d      = '0;
                    state_d  = ST_ISSUE;
                    mul_ld_d = 1'b1;
                    mul_m_d  = pick_m('0, in_a, in_b);
                    mul_r_d  = pick_r('0, in_c, in_d);
                end
            end
            ST_ISSUE: begin
                state_d      = ST_WAIT;
                wait_first_d = 1'b1;
            end
            ST_WAIT: begin
                // A Valid in the cycle right after Ld is a leftover from the
                // multiplier's previous run and is dropped.
                if (mul_valid && !wait_first_q) begin
                    case (k_q)
                        2'd0:    re_d = p_ext;
                        2'd1:    re_d = re_q - p_ext;
                        2'd2:    im_d = p_ext;
                        default: im_d = im_q + p_ext;
                    endcase
                    if (k_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d      = step_t'(k_q + 2'd1);
                        state_d  = ST_ISSUE;
                        mul_ld_d = 1'b1;
                        mul_m_d  = pick_m(k_d, opa_q, opb_q);
                        mul_r_d  = pick_r(k_d, opc_q, opd_q);
                    end
                end
            end
            ST_DONE: begin
                if (out_valid && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            opc_q        <= '0;
            opd_q        <= '0;
            re_q         <= '0;
            im_q         <= '0;
            wait_first_q <= 1'b0;
            mul_ld_q     <= 1'b0;
            mul_m_q      <= '0;
            mul_r_q      <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            opc_q        <= opc_d;
            opd_q        <= opd_d;
            re_q         <= re_d;
            im_q         <= im_d;
            wait_first_q <= wait_first_d;
            mul_ld_q     <= mul_ld_d;
            mul_m_q      <= mul_m_d;
            mul_r_q      <= mul_r_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign mul_ld   = mul_ld_q;
    assign mul_m    = mul_m_q;
    assign mul_r    = mul_r_q;

`ifdef CMUL_ROUND_SAT_EN
    cmul_round_sat #(
        .N  (N),
        .OW (OW)
    ) u_round_sat (
        .clk       (Clk),
        .rst       (Rst),
        .in_valid  (done_q),
        .in_re     (re_q),
        .in_im     (im_q),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_im    (out_im)
    );
`else
    assign out_valid = done_q;
    assign out_re    = re_q;
    assign out_im    = im_q;
`endif

endmodule

// File: tb/tb_cmul_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cmul_mul_sequencer
// Bench for cmul_mul_sequencer with a behavioural radix-4 Booth multiplier
// model (exact signed product, latency mul_lat(N), leftover Valid when Ld hits
// its last count). Expected results come from complex arithmetic on the
// operands, rounded/saturated in the bench when CMUL_ROUND_SAT_EN is defined.
// -----------------------------------------------------------------------------
module tb_cmul_mul_sequencer;

    localparam int unsigned N  = 16;
    localparam int unsigned PW = 2 * N;
    localparam int unsigned OW = 2 * N + 1;
    localparam int unsigned LAT = cmul_pkg::mul_lat(N);
`ifdef CMUL_ROUND_SAT_EN
    localparam int LAT_EXP = 4 * (LAT + 1) + 1;
`else
    localparam int LAT_EXP = 4 * (LAT + 1);
`endif

    logic                 Clk = 1'b0;
    logic                 Rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         in_a, in_b, in_c, in_d;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_re, out_im;
    logic                 busy;
    logic                 mul_ld;
    logic [N-1:0]         mul_m, mul_r;
    logic                 mul_valid;
    logic [PW-1:0]        mul_p;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    cmul_mul_sequencer #(
        .N  (N),
        .PW (PW),
        .OW (OW)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .busy      (busy),
        .mul_ld    (mul_ld),
        .mul_m     (mul_m),
        .mul_r     (mul_r),
        .mul_valid (mul_valid),
        .mul_p     (mul_p)
    );

    // Multiplier model: not reset by Rst, it is a separate block.
    logic [7:0]    mcnt = '0;
    logic          mv = 1'b0;
    logic [PW-1:0] mp = '0;
    logic [PW-1:0] mp_hold = '0;
    logic          inj = 1'b0;

    always @(posedge Clk) begin
        mv <= (mcnt == 8'd1);
        if (mcnt == 8'd1) mp <= mp_hold;
        if (mul_ld) begin
            mp_hold <= PW'(longint'($signed(mul_m)) * longint'($signed(mul_r)));
            mcnt    <= 8'(LAT - 1);
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 8'd1;
        end
    end

    assign mul_valid = mv | inj;
    assign mul_p     = inj ? 32'h7A5C_3E91 : mp;

    // Record every Ld pulse with its operand pair.
    logic [2*N-1:0] ld_q[$];
    always @(negedge Clk) if (mul_ld) ld_q.push_back({mul_m, mul_r});

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint fin(input longint x);
`ifdef CMUL_ROUND_SAT_EN
        longint y;
        y = (x + 64'sd16384) >>> 15;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
`else
        return x;
`endif
    endfunction

    task automatic issue_op(input longint a, input longint b, input longint c, input longint d,
                            output int acc_cyc);
        int t;
        in_a = N'(a);
        in_b = N'(b);
        in_c = N'(c);
        in_d = N'(d);
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge Clk);
            t++;
        end
        chk("accept_in_time", longint'(t < 200), 1);
        acc_cyc = cyc + 1;
        @(negedge Clk);
        in_valid = 1'b0;
    endtask

    task automatic get_result(input longint a, input longint b, input longint c, input longint d,
                              input int acc_cyc, input int hold);
        int t;
        longint ere, eim;
        ere = fin(a * c - b * d);
        eim = fin(a * d + b * c);
        out_ready = (hold == 0);
        t = 0;
        while (!out_valid && t < 300) begin
            @(negedge Clk);
            t++;
        end
        chk("out_valid_in_time", longint'(out_valid), 1);
        chk("latency", longint'(cyc - acc_cyc), LAT_EXP);
        chk("out_re", longint'($signed(out_re)), ere);
        chk("out_im", longint'($signed(out_im)), eim);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_re", longint'($signed(out_re)), ere);
            chk("hold_im", longint'($signed(out_im)), eim);
            chk("hold_in_ready", longint'(in_ready), 0);
            inj = (i == 2);
            @(negedge Clk);
        end
        inj = 1'b0;
        out_ready = 1'b1;
        @(negedge Clk);
        chk("valid_after_accept", longint'(out_valid), 0);
    endtask

    initial begin
        int acc;
        int t;
        longint ra, rb, rc, rd;
        logic [2*N-1:0] pair;

        Rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_a = '0;
        in_b = '0;
        in_c = '0;
        in_d = '0;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_mul_ld", longint'(mul_ld), 0);
        chk("rst_mul_m", longint'(mul_m), 0);
        chk("rst_mul_r", longint'(mul_r), 0);
        chk("rst_out_re", longint'($signed(out_re)), 0);
        chk("rst_out_im", longint'($signed(out_im)), 0);
        Rst = 1'b0;
        @(negedge Clk);
        chk("idle_in_ready", longint'(in_ready), 1);

        // Basic product, Ld pulse count and operand pairs.
        ld_q.delete();
        issue_op(3, 4, 5, 6, acc);
        chk("busy_running", longint'(busy), 1);
        get_result(3, 4, 5, 6, acc, 0);
        chk("ld_count", longint'(ld_q.size()), 4);
        if (ld_q.size() == 4) begin
            pair = {16'(3), 16'(5)}; chk("pair0", longint'(ld_q[0]), longint'(pair));
            pair = {16'(4), 16'(6)}; chk("pair1", longint'(ld_q[1]), longint'(pair));
            pair = {16'(3), 16'(6)}; chk("pair2", longint'(ld_q[2]), longint'(pair));
            pair = {16'(4), 16'(5)}; chk("pair3", longint'(ld_q[3]), longint'(pair));
        end
        @(negedge Clk);
        chk("busy_idle", longint'(busy), 0);

        // Extreme operands: no wrap at OW bits.
        issue_op(-32768, -32768, -32768, 32767, acc);
        get_result(-32768, -32768, -32768, 32767, acc, 0);

        // Backpressure with the next operand set already waiting.
        issue_op(1234, -567, -8910, 1112, acc);
        in_a = N'(-300); in_b = N'(200); in_c = N'(-100); in_d = N'(50);
        in_valid = 1'b1;
        get_result(1234, -567, -8910, 1112, acc, 7);
        issue_op(-300, 200, -100, 50, acc);
        get_result(-300, 200, -100, 50, acc, 0);

        // Reset in the middle of the k=2 wait; the leftover Valid must not leak.
        ld_q.delete();
        issue_op(111, 222, 333, 444, acc);
        t = 0;
        while (ld_q.size() < 3 && t < 200) begin
            @(negedge Clk);
            #1;
            t++;
        end
        chk("reached_k2", longint'(ld_q.size()), 3);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_mul_ld", longint'(mul_ld), 0);
        chk("midrst_in_ready", longint'(in_ready), 0);
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge Clk);
            chk("postrst_no_valid", longint'(out_valid), 0);
            chk("postrst_idle", longint'(busy), 0);
        end
        issue_op(1, 0, 0, 1, acc);
        get_result(1, 0, 0, 1, acc, 0);

        // Leftover Valid injected in the first wait cycle of step 1.
        ld_q.delete();
        issue_op(2, -1, 7, 3, acc);
        t = 0;
        while (ld_q.size() < 2 && t < 200) begin
            @(negedge Clk);
            #1;
            t++;
        end
        @(negedge Clk);
        inj = 1'b1;
        @(negedge Clk);
        inj = 1'b0;
        get_result(2, -1, 7, 3, acc, 0);

        // Fractional-mode reference points (full precision when feature off).
        issue_op(16384, 0, 16384, 0, acc);
        get_result(16384, 0, 16384, 0, acc, 0);
        issue_op(-32768, 0, -32768, 0, acc);
        get_result(-32768, 0, -32768, 0, acc, 0);

        // Random operand sets with random backpressure.
        for (int i = 0; i < 10; i++) begin
            ra = longint'($signed(16'($urandom)));
            rb = longint'($signed(16'($urandom)));
            rc = longint'($signed(16'($urandom)));
            rd = longint'($signed(16'($urandom)));
            issue_op(ra, rb, rc, rd, acc);
            get_result(ra, rb, rc, rd, acc, int'($urandom_range(0, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
